instruction_fetch_unit: RTL

//  Upstream neighbour of Instruction_Decode: holds the PC, drives instruction-memory address, presents the
//  16-bit instruction word to decode, and computes next PC from decode's PC-control flags.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/next_pc_sel.sv | 59 +++++
 rtl/instruction_fetch_unit.sv | 119 +++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit.
//   state_t  : run-control FSM encoding (idle, running, halted)
//   OFF8_W   : width of the short branch offset field, instruction[7:0]
//   OFF11_W  : width of the long jump offset field, instruction[10:0]
//   NOP_WORD : word presented to decode whenever the machine is not running
package fetch_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_HALT = 2'd2
   } state_t;

   localparam int          OFF8_W   = 8;
   localparam int          OFF11_W  = 11;
   localparam logic [15:0] NOP_WORD = 16'h0000;

endpackage : fetch_pkg

// File: rtl/next_pc_sel.sv
// Combinational next-PC selection for the fetch unit.
// Ports:
//   pc            in   current program counter
//   instr_off     in   instruction[10:0], source of the PC-relative offset
//   rm_data       in   register read port A (jump target for flag_rm_pc)
//   rd_data       in   register read port B (jump target for flag_rd_pc)
//   flag_hlt      in   halt: PC holds
//   flag_rm_pc    in   jump to rm_data
//   flag_rd_pc    in   jump to rd_data
//   flag_label_pc in   PC-relative jump, pc + 1 + sext(offset)
//   branch        in   selects the 8-bit offset field instead of the 11-bit one
//   next_pc       out  PC to load at the next retiring edge
//   pc_plus1      out  pc + 1, also used as the link value
module next_pc_sel
   import fetch_pkg::*;
#(
   parameter int PC_W = 16
) (
   input  logic [PC_W-1:0]    pc,
   input  logic [OFF11_W-1:0] instr_off,
   input  logic [15:0]        rm_data,
   input  logic [15:0]        rd_data,
   input  logic               flag_hlt,
   input  logic               flag_rm_pc,
   input  logic               flag_rd_pc,
   input  logic               flag_label_pc,
   input  logic               branch,
   output logic [PC_W-1:0]    next_pc,
   output logic [PC_W-1:0]    pc_plus1
);

   logic [PC_W-1:0] off_sext;

   assign pc_plus1 = pc + PC_W'(1);

   // Sign-extend whichever offset field the instruction form uses; the add
   // then wraps naturally modulo 2^PC_W for both directions.
   always_comb begin
      off_sext = '0;
      if (branch)
         off_sext = {{(PC_W-OFF8_W){instr_off[OFF8_W-1]}}, instr_off[OFF8_W-1:0]};
      else
         off_sext = {{(PC_W-OFF11_W){instr_off[OFF11_W-1]}}, instr_off};
   end

   // Halt beats every jump; register jumps beat the relative jump.
   always_comb begin
      next_pc = pc_plus1;
      if (flag_hlt)
         next_pc = pc;
      else if (flag_rm_pc)
         next_pc = rm_data[PC_W-1:0];
      else if (flag_rd_pc)
         next_pc = rd_data[PC_W-1:0];
      else if (flag_label_pc)
         next_pc = pc_plus1 + off_sext;
   end

endmodule : next_pc_sel

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: holds the PC, addresses instruction memory, hands
// the fetched word to decode and advances the PC from decode's flags. A small
// run-control FSM (idle / run / halt) gates execution, and a counter tracks
// instructions retired since reset or the last restart.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             pulse: leave idle, or restart from halt at RESET_PC
//   imem_addr         instruction memory address (equals pc)
//   imem_data         instruction memory read data (combinational)
//   instruction       word to decode, NOP when not running
//   instr_valid       high only while running
//   pc, pc_plus1      current PC and its successor (link value)
//   halted            high while halted
//   instr_count       retired-instruction count
//   flag_HLT, flag_label_PC, flag_Rm_PC, flag_Rd_PC, BRANCH  decode flags
//   rm_data, rd_data  register-file read ports used as jump targets
module instruction_fetch_unit
   import fetch_pkg::*;
#(
   parameter int              PC_W     = 16,
   parameter logic [PC_W-1:0] RESET_PC = '0,
   parameter int              CNT_W    = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic [PC_W-1:0]   imem_addr,
   input  logic [15:0]       imem_data,
   output logic [15:0]       instruction,
   output logic              instr_valid,
   output logic [PC_W-1:0]   pc,
   output logic [PC_W-1:0]   pc_plus1,
   output logic              halted,
   output logic [CNT_W-1:0]  instr_count,
   input  logic              flag_HLT,
   input  logic              flag_label_PC,
   input  logic              flag_Rm_PC,
   input  logic              flag_Rd_PC,
   input  logic              BRANCH,
   input  logic [15:0]       rm_data,
   input  logic [15:0]       rd_data
);

   state_t           state_q, state_d;
   logic [PC_W-1:0]  pc_q, pc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [PC_W-1:0]  next_pc;
   logic             running;

   assign running = (state_q == S_RUN);

   next_pc_sel #(
      .PC_W (PC_W)
   ) u_next_pc_sel (
      .pc            (pc_q),
      .instr_off     (instruction[OFF11_W-1:0]),
      .rm_data       (rm_data),
      .rd_data       (rd_data),
      .flag_hlt      (flag_HLT),
      .flag_rm_pc    (flag_Rm_PC),
      .flag_rd_pc    (flag_Rd_PC),
      .flag_label_pc (flag_label_PC),
      .branch        (BRANCH),
      .next_pc       (next_pc),
      .pc_plus1      (pc_plus1)
   );

   // Run control. Decode flags only matter while running; start is ignored
   // while running, so a start arriving with HLT still ends in halt.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         S_IDLE: begin
            if (start)
               state_d = S_RUN;
         end
         S_RUN: begin
            pc_d  = next_pc;
            cnt_d = cnt_q + CNT_W'(1);
            if (flag_HLT)
               state_d = S_HALT;
         end
         S_HALT: begin
            if (start) begin
               state_d = S_RUN;
               pc_d    = RESET_PC;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = S_IDLE;
            pc_d    = RESET_PC;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         pc_q    <= RESET_PC;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         cnt_q   <= cnt_d;
      end
   end

   assign imem_addr   = pc_q;
   assign pc          = pc_q;
   assign instruction = running ? imem_data : NOP_WORD;
   assign instr_valid = running;
   assign halted      = (state_q == S_HALT);
   assign instr_count = cnt_q;

endmodule : instruction_fetch_unit
